// File: rtl/hippo_issue_ctrl.sv
// rtl/hippo_issue_ctrl.sv - in-order issue controller between fetch and the decode/execute datapath
module hippo_issue_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_instr,
  input  logic [31:0] i_fetch_pc,
  output logic        o_fetch_ready,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic        o_id_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic [4:0]  i_dec_rd,
  input  logic        i_dec_rf_we,
  input  logic        i_dec_load,
  input  logic        i_dec_store,
  input  logic        i_dec_jump,
  input  logic        i_dec_branch,
  input  logic        i_dec_trap,
  input  logic        i_branch_taken,
  output logic        o_issue,
  output logic        o_pc_sel,
  output logic        o_flush,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  output logic        o_trap,
  output logic [31:0] o_trap_pc,
  input  logic        i_trap_ack,
  output logic [31:0] o_instret
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, TRAP} state_e;

  state_e      state_q, state_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_load_q, ex_load_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        hazard;
  logic        redirect;

  // Load in execute whose destination feeds the ID instruction: stall one cycle
  assign hazard = id_valid_q && ex_valid_q && ex_load_q && (ex_rd_q != 5'd0) &&
                  ((ex_rd_q == i_dec_rs1) || (ex_rd_q == i_dec_rs2));
  assign redirect = i_dec_jump || (i_dec_branch && i_branch_taken);

  assign o_id_instr = id_instr_q;
  assign o_id_pc    = id_pc_q;
  assign o_id_valid = id_valid_q;
  assign o_mem_req  = (state_q == MEM_WAIT);
  assign o_trap     = (state_q == TRAP);
  assign o_trap_pc  = trap_pc_q;
  assign o_instret  = instret_q;

  // Next-state, ID/EX register updates and issue/redirect pulses
  always_comb begin
    state_d       = state_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    ex_valid_d    = ex_valid_q;
    ex_rd_d       = ex_rd_q;
    ex_load_d     = ex_load_q;
    instret_d     = instret_q;
    trap_pc_d     = trap_pc_q;
    o_issue       = 1'b0;
    o_pc_sel      = 1'b0;
    o_flush       = 1'b0;
    o_fetch_ready = 1'b0;
    case (state_q)
      RUN: begin
        if (id_valid_q) begin
          if (i_dec_trap) begin
            trap_pc_d  = id_pc_q;
            state_d    = TRAP;
            id_valid_d = 1'b0;
          end else if (!hazard) begin
            o_issue    = 1'b1;
            instret_d  = instret_q + 32'd1;
            id_valid_d = 1'b0;
            if (redirect) begin
              o_pc_sel = 1'b1;
              o_flush  = 1'b1;
              state_d  = FLUSH;
            end else if (i_dec_load || i_dec_store) begin
              state_d = MEM_WAIT;
            end
          end
        end
        if (o_issue) begin
          ex_valid_d = i_dec_rf_we && (i_dec_rd != 5'd0);
          ex_rd_d    = i_dec_rd;
          ex_load_d  = i_dec_load;
        end else begin
          ex_valid_d = 1'b0;
        end
        o_fetch_ready = !id_valid_q || o_issue;
        // A redirect discards whatever fetch offers alongside it
        if (i_fetch_valid && o_fetch_ready && !o_flush) begin
          id_valid_d = 1'b1;
          id_instr_d = i_fetch_instr;
          id_pc_d    = i_fetch_pc;
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          state_d    = RUN;
          ex_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      TRAP: begin
        if (i_trap_ack) begin
          state_d    = RUN;
          id_valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and register update with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= RUN;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0000_0013;
      id_pc_q    <= 32'd0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_load_q  <= 1'b0;
      instret_q  <= 32'd0;
      trap_pc_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_load_q  <= ex_load_d;
      instret_q  <= instret_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

endmodule

// File: tb/tb_hippo_issue_ctrl.sv
// tb/tb_hippo_issue_ctrl.sv - self-checking bench for hippo_issue_ctrl
module tb_hippo_issue_ctrl;

  logic        i_clk, i_reset;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_instr, i_fetch_pc;
  logic        o_fetch_ready;
  logic [31:0] o_id_instr, o_id_pc;
  logic        o_id_valid;
  logic [4:0]  i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic        i_dec_rf_we, i_dec_load, i_dec_store, i_dec_jump, i_dec_branch, i_dec_trap;
  logic        i_branch_taken;
  logic        o_issue, o_pc_sel, o_flush, o_mem_req, i_mem_ack, o_trap;
  logic [31:0] o_trap_pc;
  logic        i_trap_ack;
  logic [31:0] o_instret;

  hippo_issue_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_fetch_valid(i_fetch_valid), .i_fetch_instr(i_fetch_instr), .i_fetch_pc(i_fetch_pc),
    .o_fetch_ready(o_fetch_ready),
    .o_id_instr(o_id_instr), .o_id_pc(o_id_pc), .o_id_valid(o_id_valid),
    .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd),
    .i_dec_rf_we(i_dec_rf_we), .i_dec_load(i_dec_load), .i_dec_store(i_dec_store),
    .i_dec_jump(i_dec_jump), .i_dec_branch(i_dec_branch), .i_dec_trap(i_dec_trap),
    .i_branch_taken(i_branch_taken),
    .o_issue(o_issue), .o_pc_sel(o_pc_sel), .o_flush(o_flush),
    .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack),
    .o_trap(o_trap), .o_trap_pc(o_trap_pc), .i_trap_ack(i_trap_ack),
    .o_instret(o_instret)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit rstn; bit fv; logic [31:0] instr; logic [31:0] pc;
    logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    bit we; bit ld; bit st; bit jmp; bit br; bit tk; bit trp; bit mack; bit tack;
  } in_t;

  typedef struct {
    in_t in; bit e_issue; bit e_ready; bit e_pcsel; logic [31:0] e_instret;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 run, 1 waiting on memory, 2 redirect recovery, 3 trapped
  int          m_mode = 0;
  bit          m_ok = 0;
  bit          m_idv = 0;
  logic [31:0] m_instr = 32'h13, m_pc = 0, m_cnt = 0, m_tpc = 0;
  logic [4:0]  m_pend = 0;
  bit          e_iss, e_red, e_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(bit fv, logic [31:0] pc, logic [4:0] rd, bit jmp);
    in_t r;
    r = '{default: 0};
    r.rstn = 1; r.fv = fv; r.pc = pc; r.instr = 32'h0010_0093 + pc;
    r.rd = rd; r.we = 1; r.jmp = jmp;
    return r;
  endfunction

  task automatic apply(input in_t v);
    i_reset = v.rstn; i_fetch_valid = v.fv; i_fetch_instr = v.instr; i_fetch_pc = v.pc;
    i_dec_rs1 = v.rs1; i_dec_rs2 = v.rs2; i_dec_rd = v.rd; i_dec_rf_we = v.we;
    i_dec_load = v.ld; i_dec_store = v.st; i_dec_jump = v.jmp; i_dec_branch = v.br;
    i_branch_taken = v.tk; i_dec_trap = v.trp; i_mem_ack = v.mack; i_trap_ack = v.tack;
  endtask

  task automatic model_eval(input in_t v);
    bit hz;
    hz    = (m_pend != 0) && ((m_pend == v.rs1) || (m_pend == v.rs2));
    e_iss = (m_mode == 0) && m_idv && !v.trp && !hz;
    e_red = e_iss && (v.jmp || (v.br && v.tk));
    e_rdy = (m_mode == 0) && (!m_idv || e_iss);
  endtask

  task automatic model_check();
    chk("issue", o_issue, e_iss);
    chk("pc_sel", o_pc_sel, e_red);
    chk("flush", o_flush, e_red);
    chk("fetch_ready", o_fetch_ready, e_rdy);
    chk("mem_req", o_mem_req, m_mode == 1);
    chk("trap", o_trap, m_mode == 3);
    chk("trap_pc", o_trap_pc, m_tpc);
    chk("id_valid", o_id_valid, m_idv);
    chk("id_instr", o_id_instr, m_instr);
    chk("id_pc", o_id_pc, m_pc);
    chk("instret", o_instret, m_cnt);
  endtask

  task automatic model_step(input in_t v);
    bit take;
    if (!v.rstn) begin
      m_mode = 0; m_idv = 0; m_instr = 32'h13; m_pc = 0; m_pend = 0; m_cnt = 0; m_tpc = 0;
      m_ok = 1;
    end else begin
      case (m_mode)
        0: begin
          take = v.fv && e_rdy && !e_red;
          if (m_idv && v.trp) begin
            m_tpc = m_pc; m_mode = 3; m_idv = 0;
          end else if (e_iss) begin
            m_cnt = m_cnt + 1;
            m_idv = 0;
            if (e_red) m_mode = 2;
            else if (v.ld || v.st) m_mode = 1;
          end
          m_pend = (e_iss && v.ld && v.we && v.rd != 0) ? v.rd : 5'd0;
          if (take) begin
            m_idv = 1; m_instr = v.instr; m_pc = v.pc;
          end
        end
        1: if (v.mack) begin m_mode = 0; m_pend = 0; end
        2: m_mode = 0;
        default: if (v.tack) begin m_mode = 0; m_idv = 0; end
      endcase
    end
  endtask

  task automatic pre(input in_t v);
    apply(v);
    #1;
    model_eval(v);
    if (m_ok) model_check();
  endtask

  task automatic post(input in_t v);
    @(posedge i_clk);
    model_step(v);
    @(negedge i_clk);
  endtask

  task automatic cycle(input in_t v);
    pre(v);
    post(v);
  endtask

  vec_t tbl[11];
  in_t  v, idle;

  initial begin
    idle = mk(0, 0, 0, 0);
    idle.we = 0;
    @(negedge i_clk);
    v = idle; v.rstn = 0;
    cycle(v);
    cycle(v);
    pre(idle);
    chk("rst_id_valid", o_id_valid, 0);
    chk("rst_id_instr", o_id_instr, 32'h13);
    chk("rst_id_pc", o_id_pc, 0);
    chk("rst_instret", o_instret, 0);
    chk("rst_trap_pc", o_trap_pc, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_trap", o_trap, 0);
    post(idle);

    // Straight-line ALU code, then JAL at 0x10 with 0x14 offered alongside
    tbl[0]  = '{mk(1, 32'h00, 1, 0), 0, 1, 0, 0};
    tbl[1]  = '{mk(1, 32'h04, 2, 0), 1, 1, 0, 0};
    tbl[2]  = '{mk(1, 32'h08, 3, 0), 1, 1, 0, 1};
    tbl[3]  = '{mk(1, 32'h0C, 4, 0), 1, 1, 0, 2};
    tbl[4]  = '{mk(0, 32'h00, 5, 0), 1, 1, 0, 3};
    tbl[5]  = '{mk(1, 32'h10, 0, 0), 0, 1, 0, 4};
    tbl[5].in.instr = 32'h0300_006F;
    tbl[6]  = '{mk(1, 32'h14, 1, 1), 1, 1, 1, 4};
    tbl[7]  = '{mk(1, 32'h14, 1, 0), 0, 0, 0, 5};
    tbl[8]  = '{mk(1, 32'h40, 1, 0), 0, 1, 0, 5};
    tbl[9]  = '{mk(0, 32'h00, 7, 0), 1, 1, 0, 5};
    tbl[10] = '{mk(0, 32'h00, 0, 0), 0, 1, 0, 6};
    for (int i = 0; i < 11; i++) begin
      pre(tbl[i].in);
      chk($sformatf("tbl%0d_issue", i), o_issue, tbl[i].e_issue);
      chk($sformatf("tbl%0d_ready", i), o_fetch_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_pc_sel", i), o_pc_sel, tbl[i].e_pcsel);
      chk($sformatf("tbl%0d_instret", i), o_instret, tbl[i].e_instret);
      post(tbl[i].in);
    end

    // LW x5 then ADD x6,x5,x1 with a two-cycle memory wait
    cycle(mk(1, 32'h50, 0, 0));
    v = mk(1, 32'h54, 5, 0); v.ld = 1; v.rs1 = 1;
    pre(v); chk("lw_issue", o_issue, 1); post(v);
    v = mk(1, 32'h58, 6, 0); v.rs1 = 5; v.rs2 = 1;
    pre(v); chk("lw_wait_req", o_mem_req, 1); chk("lw_wait_ready", o_fetch_ready, 0);
    chk("lw_wait_issue", o_issue, 0); post(v);
    v.mack = 1;
    pre(v); chk("lw_ack_req", o_mem_req, 1); post(v);
    v.mack = 0; v.fv = 0;
    pre(v); chk("add_issue", o_issue, 1); chk("add_req", o_mem_req, 0);
    chk("add_pc", o_id_pc, 32'h54); post(v);
    cycle(idle);

    // Illegal opcode at 0x20, held through 5 cycles, then acknowledged
    cycle(mk(1, 32'h20, 0, 0));
    v = mk(1, 32'h24, 0, 0); v.trp = 1;
    pre(v); chk("trap_noissue", o_issue, 0); chk("trap_ready", o_fetch_ready, 0); post(v);
    for (int i = 0; i < 5; i++) begin
      pre(idle); chk("trap_held", o_trap, 1); chk("trap_pc_held", o_trap_pc, 32'h20); post(idle);
    end
    v = idle; v.tack = 1;
    pre(v); chk("trap_ack_cycle", o_trap, 1); post(v);
    pre(idle); chk("trap_fall", o_trap, 0); chk("trap_idv", o_id_valid, 0); post(idle);

    // Reset while waiting on memory
    cycle(mk(1, 32'h60, 0, 0));
    v = mk(0, 0, 5, 0); v.ld = 1;
    cycle(v);
    pre(idle); chk("mw_req", o_mem_req, 1); post(idle);
    v = idle; v.rstn = 0;
    cycle(v);
    pre(idle); chk("mw_rst_req", o_mem_req, 0); chk("mw_rst_idv", o_id_valid, 0);
    chk("mw_rst_instret", o_instret, 0); post(idle);

    // Counter wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_cnt = 32'hFFFF_FFFF;
    cycle(mk(1, 32'h70, 1, 0));
    v = mk(0, 0, 1, 0);
    pre(v); chk("wrap_pre", o_instret, 32'hFFFF_FFFF); chk("wrap_issue", o_issue, 1); post(v);
    pre(idle); chk("wrap_zero", o_instret, 0); post(idle);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      v.rstn  = ($urandom_range(0, 199) != 0);
      v.fv    = ($urandom_range(0, 3) != 0);
      v.instr = $urandom;
      v.pc    = $urandom & 32'hFFFF_FFFC;
      v.rs1   = 5'($urandom_range(0, 7));
      v.rs2   = 5'($urandom_range(0, 7));
      v.rd    = 5'($urandom_range(0, 7));
      v.we    = $urandom_range(0, 1) != 0;
      v.ld    = $urandom_range(0, 4) == 0;
      v.st    = $urandom_range(0, 7) == 0;
      v.jmp   = $urandom_range(0, 9) == 0;
      v.br    = $urandom_range(0, 5) == 0;
      v.tk    = $urandom_range(0, 1) != 0;
      v.trp   = $urandom_range(0, 24) == 0;
      v.mack  = (m_mode == 1) && ($urandom_range(0, 2) == 0);
      v.tack  = $urandom_range(0, 3) == 0;
      cycle(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hippo_issue_ctrl.md
# hippo_issue_ctrl

In-order issue controller between instruction fetch and the decoder/ALU datapath. It holds the ID-stage register (instruction + PC) that feeds the decoder. It sequences each decoded instruction into execute, inserts a bubble on load-use hazards, and holds the pipe during data-memory access. It also redirects fetch on jumps and taken branches, parks the core on a trap until the trap unit acknowledges, and counts issued instructions.

## Interface
- No parameters (XLEN fixed at 32, register index fixed at 5 bits).
- i_clk  in  1  core clock; all state updates on rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_fetch_valid  in  1  fetch offers an instruction
- i_fetch_instr  in  32  offered instruction word
- i_fetch_pc  in  32  PC of offered instruction
- o_fetch_ready  out  1  controller accepts the offered instruction this cycle
- o_id_instr  out  32  ID register instruction (to decoder i_instr)
- o_id_pc  out  32  ID register PC
- o_id_valid  out  1  ID register holds a live instruction
- i_dec_rs1, i_dec_rs2  in  5 each  decoder source registers
- i_dec_rd  in  5  decoder destination register
- i_dec_rf_we  in  1  decoder register-write enable
- i_dec_load, i_dec_store  in  1 each  ID instruction is LOAD / STORE
- i_dec_jump  in  1  ID instruction is JAL or JALR
- i_dec_branch  in  1  ID instruction is a conditional branch
- i_dec_trap  in  1  decoder flagged illegal opcode
- i_branch_taken  in  1  branch comparison result for the ID instruction (combinational, same cycle)
- o_issue  out  1  ID instruction enters execute this cycle
- o_pc_sel  out  1  fetch must load the ALU target this cycle
- o_flush  out  1  discard any wrong-path fetch this cycle
- o_mem_req  out  1  data-memory request active
- i_mem_ack  in  1  data memory completes the request
- o_trap  out  1  trap pending, held until acknowledged
- o_trap_pc  out  32  PC of trapping instruction, valid while o_trap
- i_trap_ack  in  1  trap unit has vectored fetch
- o_instret  out  32  issued-instruction counter

## Operation
- States: RUN, MEM_WAIT, FLUSH, TRAP. Reset state: RUN.
- Reset (i_reset==0 at a rising edge) sets the following, regardless of current state (including mid MEM_WAIT; the memory request drops the next cycle):
  - state = RUN
  - id_valid = 0, id_instr = 0x00000013 (NOP), id_pc = 0
  - ex_valid = 0
  - o_instret = 0, o_trap_pc = 0
  - all pulse outputs = 0
- EX tracking register: ex_valid, ex_rd, ex_load. It is loaded on every issue with rd, rf_we && rd!=0, and load; it is cleared (ex_valid=0) on any non-issue cycle in RUN, and on i_mem_ack.
- hazard = id_valid && ex_valid && ex_load && ex_rd!=0 && (ex_rd==i_dec_rs1 || ex_rd==i_dec_rs2).
- o_fetch_ready = (state==RUN) && (!id_valid || o_issue).
- ID register loads fetch data when i_fetch_valid && o_fetch_ready. It clears id_valid when it issues without a new fetch, or on flush/trap.
- RUN with id_valid:
  - i_dec_trap: no issue; o_trap_pc <= id_pc; go to TRAP; id_valid <= 0. Trap has priority over hazard and redirect.
  - else hazard: no issue (one bubble); ex_valid <= 0, so issue follows the next cycle.
  - else: o_issue=1; o_instret increments, wrapping 0xFFFFFFFF to 0.
    - jump, or branch with i_branch_taken: o_pc_sel=1, o_flush=1, fetch ignored this cycle, id_valid <= 0, go to FLUSH.
    - load or store: go to MEM_WAIT.
- MEM_WAIT: o_mem_req=1; o_fetch_ready=0; ID holds. On i_mem_ack, go to RUN and clear ex_valid.
- FLUSH: one cycle, o_fetch_ready=0; return to RUN.
- TRAP: o_trap=1, o_fetch_ready=0. On i_trap_ack, go to RUN with id_valid=0.
- i_dec_* and i_branch_taken are ignored whenever !id_valid or state!=RUN.

## Timing
- Straight-line code: 1 issue per cycle. A fetch accepted at cycle N appears on o_id_* at N+1; with no hazard it issues at N+1.
- Load-use: exactly 1 bubble cycle.
- Memory op: issue at N; o_mem_req from N+1. With ack at N+k (k≥1), the next issue is no earlier than N+k+1.
- Taken redirect: o_pc_sel/o_flush pulse at the issue cycle N; FLUSH at N+1; the first target fetch is accepted at N+2; earliest target issue at N+3.
- Trap: o_trap rises the cycle after detection and falls the cycle after i_trap_ack is sampled. A same-cycle ack while o_trap is high is honoured.
- o_pc_sel, o_flush, o_issue are combinational from state plus ID/decoder inputs. o_mem_req, o_trap, and o_id_* are registered.

## Test plan
- Reset then 4 back-to-back ALU instructions at PC 0x0–0xC with fetch always valid -> o_issue high for 4 consecutive cycles starting cycle 1; o_instret=4.
- LW x5 then ADD x6,x5,x1 -> one bubble between issues; o_mem_req high until ack; the ADD issues the cycle after ack. Repeat with rd=x0 -> no bubble.
- JAL at 0x10 with a fetch of 0x14 offered simultaneously -> o_pc_sel=o_flush=1 for one cycle; 0x14 never issues; o_fetch_ready=0 for one cycle.
- Undefined opcode at 0x20 -> no issue; o_trap=1, o_trap_pc=0x20; held through 5 cycles without ack; deasserts after i_trap_ack; id_valid=0.
- Reset asserted in MEM_WAIT with ack never given -> o_mem_req=0, o_id_valid=0 and o_instret=0 the next cycle.
- Preload o_instret to 0xFFFFFFFF via 2^32-1 issues (or a force), then issue once -> o_instret=0.
